dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 29 ++
 rtl/dmem_arbiter_if.sv | 55 +++++
 rtl/dmem_arbiter.sv | 156 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared data-memory package: sizing defaults, arbiter state encoding,
// requester indices and the address range helper.
package dmem_arbiter_pkg;

    // Number of 64-bit words in data memory; addresses at or above are invalid.
    localparam int unsigned ADDR_LIMIT_DEF = 8192;
    // Consecutive r0 grants tolerated while r1 is waiting.
    localparam int unsigned STARVE_MAX_DEF = 4;

    localparam int unsigned DW     = 64;
    localparam int unsigned MEM_AW = 13;

    // Requester indices: r0 is the pipeline memory stage, r1 the loader/debug port.
    localparam logic REQ_R0 = 1'b0;
    localparam logic REQ_R1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    // True when a word address falls outside the populated memory.
    function automatic logic addr_out_of_range(input logic [63:0] addr,
                                               input logic [63:0] limit);
        return (addr >= limit);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the external memory port.
//
// Handshake: a requester raises rN_req with rN_we/rN_addr/rN_wdata stable and
// keeps them stable until rN_done. rN_gnt pulses for one cycle when the memory
// access is issued (absent for out-of-range addresses), rN_done pulses for one
// cycle when the transaction completes and qualifies rN_rdata/rN_err. A request
// still high in an IDLE cycle after rN_done counts as a new transaction.
interface dmem_arbiter_if;
    import dmem_arbiter_pkg::*;

    logic              r0_req;
    logic              r0_we;
    logic [DW-1:0]     r0_addr;
    logic [DW-1:0]     r0_wdata;
    logic              r0_gnt;
    logic              r0_done;
    logic [DW-1:0]     r0_rdata;
    logic              r0_err;

    logic              r1_req;
    logic              r1_we;
    logic [DW-1:0]     r1_addr;
    logic [DW-1:0]     r1_wdata;
    logic              r1_gnt;
    logic              r1_done;
    logic [DW-1:0]     r1_rdata;
    logic              r1_err;

    logic              mem_en;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    // Arbiter side.
    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        output r0_gnt, r0_done, r0_rdata, r0_err,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        output r1_gnt, r1_done, r1_rdata, r1_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requesters plus memory side.
    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        input  r0_gnt, r0_done, r0_rdata, r0_err,
        output r1_req, r1_we, r1_addr, r1_wdata,
        input  r1_gnt, r1_done, r1_rdata, r1_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory.
// IDLE picks a winner, ACCESS issues the memory cycle, RESP returns the result.
// r0 has priority; r1 is forced through after STARVE_MAX back-to-back r0 wins.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_LIMIT = ADDR_LIMIT_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus,
    output arb_state_e    dbg_state_o
);

    localparam int unsigned CNT_W        = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX_C = CNT_W'(STARVE_MAX);
    localparam logic [63:0]      LIMIT_C      = 64'(ADDR_LIMIT);

    arb_state_e        state_q;
    logic [CNT_W-1:0]  starve_q;
    logic              win_q;
    logic              we_q;
    logic              err_q;

    logic              mem_en_q;
    logic              mem_we_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [DW-1:0]     mem_wdata_q;
    logic              r0_gnt_q;
    logic              r1_gnt_q;
    logic              r0_done_q;
    logic              r1_done_q;
    logic              r0_err_q;
    logic              r1_err_q;

    logic              req_any;
    logic              pick_r1;
    logic              sel_we;
    logic [DW-1:0]     sel_addr;
    logic [DW-1:0]     sel_wdata;
    logic              sel_err;

    // Winner selection and mux of the winner's request fields.
    always_comb begin
        req_any   = bus.r0_req | bus.r1_req;
        pick_r1   = bus.r1_req & (~bus.r0_req | (starve_q == STARVE_MAX_C));
        sel_we    = pick_r1 ? bus.r1_we    : bus.r0_we;
        sel_addr  = pick_r1 ? bus.r1_addr  : bus.r0_addr;
        sel_wdata = pick_r1 ? bus.r1_wdata : bus.r0_wdata;
        sel_err   = addr_out_of_range(sel_addr, LIMIT_C);
    end

    // Arbiter FSM; every output except rdata is a register set on the
    // transition into the cycle where it must be seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            starve_q    <= '0;
            win_q       <= REQ_R0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            r0_gnt_q    <= 1'b0;
            r1_gnt_q    <= 1'b0;
            r0_done_q   <= 1'b0;
            r1_done_q   <= 1'b0;
            r0_err_q    <= 1'b0;
            r1_err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!bus.r1_req) begin
                        starve_q <= '0;
                    end
                    if (req_any) begin
                        win_q <= pick_r1 ? REQ_R1 : REQ_R0;
                        we_q  <= sel_we;
                        err_q <= sel_err;
                        if (pick_r1) begin
                            starve_q <= '0;
                        end else if (bus.r1_req && (starve_q != STARVE_MAX_C)) begin
                            starve_q <= starve_q + CNT_W'(1);
                        end
                        if (sel_err) begin
                            // Out of range: skip the memory cycle entirely.
                            state_q   <= ST_RESP;
                            r0_done_q <= ~pick_r1;
                            r1_done_q <= pick_r1;
                            r0_err_q  <= ~pick_r1;
                            r1_err_q  <= pick_r1;
                        end else begin
                            state_q     <= ST_ACCESS;
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= sel_we;
                            mem_addr_q  <= sel_addr[MEM_AW-1:0];
                            mem_wdata_q <= sel_we ? sel_wdata : '0;
                            r0_gnt_q    <= ~pick_r1;
                            r1_gnt_q    <= pick_r1;
                        end
                    end
                end
                ST_ACCESS: begin
                    state_q     <= ST_RESP;
                    mem_en_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    r0_gnt_q    <= 1'b0;
                    r1_gnt_q    <= 1'b0;
                    r0_done_q   <= (win_q == REQ_R0);
                    r1_done_q   <= (win_q == REQ_R1);
                end
                ST_RESP: begin
                    state_q   <= ST_IDLE;
                    r0_done_q <= 1'b0;
                    r1_done_q <= 1'b0;
                    r0_err_q  <= 1'b0;
                    r1_err_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Read data arrives from memory during RESP, so it is steered, not stored.
    always_comb begin
        bus.r0_rdata = '0;
        bus.r1_rdata = '0;
        if ((state_q == ST_RESP) && !we_q && !err_q) begin
            if (win_q == REQ_R1) begin
                bus.r1_rdata = bus.mem_rdata;
            end else begin
                bus.r0_rdata = bus.mem_rdata;
            end
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.r0_gnt    = r0_gnt_q;
    assign bus.r1_gnt    = r1_gnt_q;
    assign bus.r0_done   = r0_done_q;
    assign bus.r1_done   = r1_done_q;
    assign bus.r0_err    = r0_err_q;
    assign bus.r1_err    = r1_err_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with an external memory model and an
// expected-result queue checked on every done pulse.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int EW = 66;  // {who, err, rdata}

  logic clk;
  logic reset;
  arb_state_e dbg_state;

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .ADDR_LIMIT(8192),
    .STARVE_MAX(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  logic [63:0] ref_mem[logic [63:0]];
  logic [63:0] mem_store[0:8191];

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // external memory: registered read, data valid the cycle after mem_en
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem_store[bus.mem_addr] <= bus.mem_wdata;
      else bus.mem_rdata <= mem_store[bus.mem_addr];
    end
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, 64'({bus.r0_gnt, bus.r1_gnt, bus.r0_done, bus.r1_done,
                            bus.r0_err, bus.r1_err, bus.mem_en, bus.mem_we}), 64'd0);
    chk({tag, "_maddr"}, 64'(bus.mem_addr), 64'd0);
    chk({tag, "_mwdata"}, bus.mem_wdata, 64'd0);
    chk({tag, "_rdata"}, bus.r0_rdata | bus.r1_rdata, 64'd0);
  endtask

  task automatic drive(input logic who, input logic we, input logic [63:0] addr,
                       input logic [63:0] wdata);
    if (who) begin
      bus.r1_req = 1'b1; bus.r1_we = we; bus.r1_addr = addr; bus.r1_wdata = wdata;
    end else begin
      bus.r0_req = 1'b1; bus.r0_we = we; bus.r0_addr = addr; bus.r0_wdata = wdata;
    end
  endtask

  task automatic drop(input logic who);
    if (who) bus.r1_req = 1'b0;
    else bus.r0_req = 1'b0;
  endtask

  // expected result from the bench's own view of memory contents
  task automatic push_exp(input logic who, input logic we, input logic [63:0] addr,
                          input logic [63:0] wdata);
    logic err;
    logic [63:0] rd;
    err = (addr >= 64'd8192);
    rd = 64'd0;
    if (!err && !we) rd = ref_mem.exists(addr) ? ref_mem[addr] : 64'd0;
    if (!err && we) ref_mem[addr] = wdata;
    exp_q.push_back({who, err, rd});
  endtask

  task automatic check_done(input string tag);
    logic [EW-1:0] e;
    checks++;
    assert (exp_q.size() != 0) else begin
      failures++;
      $error("FAIL %s_sb observed=unexpected_done expected=no_done", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_done"}, 64'({bus.r1_done, bus.r0_done}), e[65] ? 64'd2 : 64'd1);
      chk({tag, "_err"}, 64'(e[65] ? bus.r1_err : bus.r0_err), 64'(e[64]));
      chk({tag, "_rdata"}, e[65] ? bus.r1_rdata : bus.r0_rdata, e[63:0]);
    end
  endtask

  // one transaction, cycle by cycle, starting from an IDLE negedge
  task automatic run_single(input string tag, input logic who, input logic we,
                            input logic [63:0] addr, input logic [63:0] wdata);
    logic err;
    err = (addr >= 64'd8192);
    drive(who, we, addr, wdata);
    push_exp(who, we, addr, wdata);
    tick();
    if (!err) begin
      chk({tag, "_gnt"}, 64'({bus.r1_gnt, bus.r0_gnt}), who ? 64'd2 : 64'd1);
      chk({tag, "_men"}, 64'(bus.mem_en), 64'd1);
      chk({tag, "_mwe"}, 64'(bus.mem_we), 64'(we));
      chk({tag, "_maddr"}, 64'(bus.mem_addr), 64'(addr[12:0]));
      if (we) chk({tag, "_mwdata"}, bus.mem_wdata, wdata);
      chk({tag, "_early"}, 64'({bus.r1_done, bus.r0_done}), 64'd0);
      chk({tag, "_st_acc"}, 64'(dbg_state), 64'(ST_ACCESS));
      tick();
    end else begin
      chk({tag, "_nognt"}, 64'({bus.r1_gnt, bus.r0_gnt}), 64'd0);
      chk({tag, "_nomen"}, 64'(bus.mem_en), 64'd0);
    end
    check_done(tag);
    chk({tag, "_respq"}, 64'({bus.r1_gnt, bus.r0_gnt, bus.mem_en}), 64'd0);
    drop(who);
    tick();
    chk_quiet({tag, "_idle"});
  endtask

  // wait for n done pulses; all-valid transactions finish every 3 cycles
  task automatic collect(input string tag, input int n, input int budget, input bit drop_each);
    int got;
    int cyc;
    logic who;
    got = 0;
    cyc = 0;
    while (got < n && cyc < budget) begin
      tick();
      cyc++;
      if (bus.r0_done || bus.r1_done) begin
        who = bus.r1_done;
        check_done(tag);
        chk({tag, "_lat"}, 64'(cyc), 64'(3 * (got + 1) - 1));
        got++;
        if (drop_each) drop(who);
        else if (got == n) begin
          drop(1'b0);
          drop(1'b1);
        end
      end
    end
    chk({tag, "_count"}, 64'(got), 64'(n));
  endtask

  initial begin
    logic [63:0] v;
    bus.r0_req = 0; bus.r0_we = 0; bus.r0_addr = 0; bus.r0_wdata = 0;
    bus.r1_req = 0; bus.r1_we = 0; bus.r1_addr = 0; bus.r1_wdata = 0;
    bus.mem_rdata = 0;
    reset = 1'b1;
    tick();
    tick();
    chk_quiet("reset");
    chk("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    reset = 1'b0;
    tick();

    // preload through the arbiter, then single read of addr 5
    run_single("wr5", 1'b1, 1'b1, 64'd5, 64'hAB);
    run_single("rd5", 1'b0, 1'b0, 64'd5, 64'd0);

    // r1 write addr 100 and read-back by r0
    run_single("wr100", 1'b1, 1'b1, 64'd100, 64'h1234);
    run_single("rd100", 1'b0, 1'b0, 64'd100, 64'd0);

    // random data at the top valid word and the starvation addresses
    v = {$urandom, $urandom};
    run_single("wr8191", 1'b0, 1'b1, 64'd8191, v);
    run_single("rd8191", 1'b1, 1'b0, 64'd8191, 64'd0);
    run_single("wr7", 1'b0, 1'b1, 64'd7, {$urandom, $urandom});
    run_single("wr9", 1'b1, 1'b1, 64'd9, {32'd0, 32'($urandom_range(1, 32'hFFFF))});

    // out-of-range: first invalid word, and a far address from r1 (write)
    run_single("err8192", 1'b0, 1'b0, 64'd8192, 64'd0);
    run_single("err_far", 1'b1, 1'b1, 64'hFFFF_0000_0000_0005, 64'h55);
    // the failed write must not have touched memory
    run_single("rd5b", 1'b0, 1'b0, 64'd5, 64'd0);

    // starvation: both continuously -> r0 x4, r1, r0
    drive(1'b0, 1'b0, 64'd7, 64'd0);
    drive(1'b1, 1'b0, 64'd9, 64'd0);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) push_exp(1'b1, 1'b0, 64'd9, 64'd0);
      else push_exp(1'b0, 1'b0, 64'd7, 64'd0);
    end
    collect("starve", 6, 24, 1'b0);
    tick();
    chk_quiet("starve_idle");

    // simultaneous first requests: r0 then r1 without r1 reasserting
    drive(1'b0, 1'b1, 64'd20, 64'hC0FFEE);
    drive(1'b1, 1'b0, 64'd20, 64'd0);
    push_exp(1'b0, 1'b1, 64'd20, 64'hC0FFEE);
    push_exp(1'b1, 1'b0, 64'd20, 64'd0);
    collect("simul", 2, 12, 1'b1);
    tick();
    chk_quiet("simul_idle");

    // reset during ACCESS aborts without done; reissue completes
    drive(1'b0, 1'b0, 64'd5, 64'd0);
    tick();
    chk("rst_pre_gnt", 64'(bus.r0_gnt), 64'd1);
    #2 reset = 1'b1;
    #1 chk_quiet("rst_async");
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    tick();
    chk("rst_nodone1", 64'({bus.r1_done, bus.r0_done}), 64'd0);
    tick();
    chk("rst_nodone2", 64'({bus.r1_done, bus.r0_done}), 64'd0);
    reset = 1'b0;
    push_exp(1'b0, 1'b0, 64'd5, 64'd0);
    tick();
    chk("reissue_gnt", 64'({bus.r1_gnt, bus.r0_gnt}), 64'd1);
    tick();
    check_done("reissue");
    drop(1'b0);
    tick();
    chk_quiet("reissue_idle");

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
